// File: rtl/instruction_fetch.sv
// Instruction fetch stage: a PC register drives a combinational instruction memory and a
// one-entry IF/ID slot with a decode handshake, branch redirect, and a sticky range/alignment fault.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] read_address,
  input  logic [31:0] instruction,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        id_ready,
  output logic        if_id_valid,
  output logic [31:0] if_id_instruction,
  output logic [63:0] if_id_pc,
  output logic        fetch_fault,
  output logic [63:0] fault_pc
);

  typedef enum logic {S_FETCH, S_FAULT} state_t;

  // Highest PC whose full 4-byte word still lies inside the memory.
  localparam logic [63:0] LAST_WORD = 64'(MEM_BYTES) - 64'd4;

  state_t      state, state_nxt;
  logic [63:0] pc;
  logic        slot_free, illegal;
  logic        capture, take_fault, drain;

  assign read_address = pc;
  assign slot_free    = !if_id_valid || id_ready;
  assign illegal      = (pc[1:0] != 2'b00) || (pc > LAST_WORD);

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (branch_taken)                      state_nxt = S_FETCH;
    else if (state == S_FETCH && illegal)  state_nxt = S_FAULT;
  end

  always_comb begin
    capture     = 1'b0;
    take_fault  = 1'b0;
    drain       = 1'b0;
    fetch_fault = (state == S_FAULT);
    if (!branch_taken) begin
      unique case (state)
        S_FETCH: begin
          if (illegal) begin
            take_fault = 1'b1;
            drain      = id_ready;
          end else if (slot_free) begin
            capture = 1'b1;
          end
        end
        S_FAULT: drain = id_ready;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc                <= RESET_PC;
      if_id_valid       <= 1'b0;
      if_id_instruction <= '0;
      if_id_pc          <= '0;
      fault_pc          <= '0;
    end else if (branch_taken) begin
      // Redirect flushes the slot even while decode is stalled.
      pc          <= branch_target;
      if_id_valid <= 1'b0;
    end else begin
      if (capture) begin
        if_id_instruction <= instruction;
        if_id_pc          <= pc;
        if_id_valid       <= 1'b1;
        pc                <= pc + 64'd4;
      end
      if (take_fault) fault_pc    <= pc;
      if (drain)      if_id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed-vector bench for instruction_fetch: memory word i at byte 4*i is "addi xi,x0,i",
// and each vector row gives the inputs for one edge and the outputs expected just after it.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] read_address;
  logic [31:0] instruction;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        id_ready;
  logic        if_id_valid;
  logic [31:0] if_id_instruction;
  logic [63:0] if_id_pc;
  logic        fetch_fault;
  logic [63:0] fault_pc;

  int n_vec = 0;
  int n_err = 0;

  instruction_fetch #(.RESET_PC(64'h0), .MEM_BYTES(128)) dut (
    .clk(clk), .reset(reset), .read_address(read_address), .instruction(instruction),
    .branch_taken(branch_taken), .branch_target(branch_target), .id_ready(id_ready),
    .if_id_valid(if_id_valid), .if_id_instruction(if_id_instruction), .if_id_pc(if_id_pc),
    .fetch_fault(fetch_fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] w(input int i);
    return (32'(i) << 20) | (32'(i) << 7) | 32'h13;
  endfunction

  function automatic logic [7:0] mbyte(input logic [63:0] a);
    logic [31:0] wd;
    wd = w(int'(a[6:2]));
    return wd[8*a[1:0] +: 8];
  endfunction

  // Little-endian memory image; out-of-range reads return a poison word.
  always_comb begin
    instruction = 32'hDEAD_BEEF;
    if (read_address <= 64'd124)
      instruction = {mbyte(read_address + 64'd3), mbyte(read_address + 64'd2),
                     mbyte(read_address + 64'd1), mbyte(read_address)};
  end

  typedef struct {
    logic        rst, br;
    logic [63:0] tgt;
    logic        rdy;
    logic        e_vld, chk_data;
    logic [63:0] e_pc;
    logic [31:0] e_ins;
    logic [63:0] e_ra;
    logic        e_flt;
    logic [63:0] e_fpc;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic br, input logic [63:0] tgt,
                              input logic rdy, input logic e_vld, input logic chk,
                              input logic [63:0] e_pc, input logic [31:0] e_ins,
                              input logic [63:0] e_ra, input logic e_flt, input logic [63:0] e_fpc);
    vec_t v;
    v.rst = rst; v.br = br; v.tgt = tgt; v.rdy = rdy; v.e_vld = e_vld; v.chk_data = chk;
    v.e_pc = e_pc; v.e_ins = e_ins; v.e_ra = e_ra; v.e_flt = e_flt; v.e_fpc = e_fpc;
    return v;
  endfunction

  task automatic apply(input string name, input vec_t v);
    logic bad;
    reset = v.rst; branch_taken = v.br; branch_target = v.tgt; id_ready = v.rdy;
    @(posedge clk);
    #1;
    n_vec++;
    bad = (if_id_valid !== v.e_vld) || (read_address !== v.e_ra) ||
          (fetch_fault !== v.e_flt) || (fault_pc !== v.e_fpc);
    if (v.chk_data) bad = bad || (if_id_pc !== v.e_pc) || (if_id_instruction !== v.e_ins);
    if (bad) begin
      n_err++;
      $display("FAIL %s: got vld=%0b pc=%h ins=%h ra=%h flt=%0b fpc=%h; want vld=%0b pc=%h ins=%h ra=%h flt=%0b fpc=%h",
               name, if_id_valid, if_id_pc, if_id_instruction, read_address, fetch_fault, fault_pc,
               v.e_vld, v.e_pc, v.e_ins, v.e_ra, v.e_flt, v.e_fpc);
    end
  endtask

  vec_t tv[26];

  initial begin
    //              rst br tgt     rdy vld chk pc      ins     ra      flt fpc
    tv[0]  = mk(1, 0, 64'h0,  1, 0, 1, 64'h0,  32'h0, 64'h0,  0, 64'h0);   // reset state
    tv[1]  = mk(0, 0, 64'h0,  1, 1, 1, 64'h0,  w(0),  64'h4,  0, 64'h0);   // first capture
    tv[2]  = mk(0, 0, 64'h0,  1, 1, 1, 64'h4,  w(1),  64'h8,  0, 64'h0);
    tv[3]  = mk(0, 0, 64'h0,  0, 1, 1, 64'h4,  w(1),  64'h8,  0, 64'h0);   // stall x3
    tv[4]  = mk(0, 0, 64'h0,  0, 1, 1, 64'h4,  w(1),  64'h8,  0, 64'h0);
    tv[5]  = mk(0, 0, 64'h0,  0, 1, 1, 64'h4,  w(1),  64'h8,  0, 64'h0);
    tv[6]  = mk(0, 0, 64'h0,  1, 1, 1, 64'h8,  w(2),  64'hC,  0, 64'h0);
    tv[7]  = mk(0, 1, 64'h40, 0, 0, 0, 64'h0,  32'h0, 64'h40, 0, 64'h0);   // branch while stalled
    tv[8]  = mk(0, 0, 64'h0,  0, 1, 1, 64'h40, w(16), 64'h44, 0, 64'h0);
    tv[9]  = mk(0, 1, 64'h78, 1, 0, 0, 64'h0,  32'h0, 64'h78, 0, 64'h0);
    tv[10] = mk(0, 0, 64'h0,  1, 1, 1, 64'h78, w(30), 64'h7C, 0, 64'h0);
    tv[11] = mk(0, 0, 64'h0,  1, 1, 1, 64'h7C, w(31), 64'h80, 0, 64'h0);
    tv[12] = mk(0, 0, 64'h0,  0, 1, 1, 64'h7C, w(31), 64'h80, 1, 64'h80);  // range fault, slot held
    tv[13] = mk(0, 0, 64'h0,  0, 1, 1, 64'h7C, w(31), 64'h80, 1, 64'h80);
    tv[14] = mk(0, 0, 64'h0,  1, 0, 0, 64'h0,  32'h0, 64'h80, 1, 64'h80);  // drain
    tv[15] = mk(0, 0, 64'h0,  1, 0, 0, 64'h0,  32'h0, 64'h80, 1, 64'h80);
    tv[16] = mk(0, 1, 64'h10, 1, 0, 0, 64'h0,  32'h0, 64'h10, 0, 64'h80);  // branch clears fault
    tv[17] = mk(0, 0, 64'h0,  1, 1, 1, 64'h10, w(4),  64'h14, 0, 64'h80);
    tv[18] = mk(0, 1, 64'h22, 1, 0, 0, 64'h0,  32'h0, 64'h22, 0, 64'h80);  // misaligned target
    tv[19] = mk(0, 0, 64'h0,  1, 0, 0, 64'h0,  32'h0, 64'h22, 1, 64'h22);
    tv[20] = mk(1, 1, 64'h40, 1, 0, 1, 64'h0,  32'h0, 64'h0,  0, 64'h0);   // reset beats branch in FAULT
    tv[21] = mk(0, 0, 64'h0,  1, 1, 1, 64'h0,  w(0),  64'h4,  0, 64'h0);
    tv[22] = mk(0, 0, 64'h0,  1, 1, 1, 64'h4,  w(1),  64'h8,  0, 64'h0);
    tv[23] = mk(0, 0, 64'h0,  0, 1, 1, 64'h4,  w(1),  64'h8,  0, 64'h0);
    tv[24] = mk(1, 0, 64'h0,  0, 0, 1, 64'h0,  32'h0, 64'h0,  0, 64'h0);   // reset mid-stall
    tv[25] = mk(0, 0, 64'h0,  0, 1, 1, 64'h0,  w(0),  64'h4,  0, 64'h0);   // empty slot captures despite !id_ready

    reset = 1'b1; branch_taken = 1'b0; branch_target = '0; id_ready = 1'b0;
    for (int i = 0; i < 26; i++) apply($sformatf("vec%0d", i), tv[i]);

    // Aligned target past the top of memory: accepted, then faults while the flushed slot stays empty.
    apply("hi_target_accept", mk(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 64'h0, 32'h0,
                                 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0));
    apply("hi_target_fault",  mk(0, 0, 64'h0, 0, 0, 0, 64'h0, 32'h0,
                                 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'hFFFF_FFFF_FFFF_FFFC));
    apply("hi_target_hold",   mk(0, 0, 64'h0, 1, 0, 0, 64'h0, 32'h0,
                                 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'hFFFF_FFFF_FFFF_FFFC));

    // Last legal word (124) captures normally, then 128 faults with id_ready high draining the slot.
    apply("edge_branch", mk(0, 1, 64'h7C, 1, 0, 0, 64'h0, 32'h0, 64'h7C, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC));
    apply("edge_cap",    mk(0, 0, 64'h0, 1, 1, 1, 64'h7C, w(31), 64'h80, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC));
    apply("edge_fault",  mk(0, 0, 64'h0, 1, 0, 0, 64'h0, 32'h0, 64'h80, 1'b1, 64'h80));
    apply("edge_reset",  mk(1, 0, 64'h0, 1, 0, 1, 64'h0, 32'h0, 64'h0, 1'b0, 64'h0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL be the PC value loaded on reset.
REQ-002 Parameter MEM_BYTES, default 128, SHALL be the instruction memory size in bytes, used for the fetch range check.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 read_address  output  64  SHALL be the current PC, driven to the instruction memory byte address.
REQ-006 instruction  input  32  SHALL be the combinational memory read data for read_address, little-endian: byte at read_address is in [7:0].
REQ-007 branch_taken  input  1  SHALL be the redirect request from the downstream stage.
REQ-008 branch_target  input  64  SHALL be the redirect PC, valid when branch_taken=1.
REQ-009 id_ready  input  1  SHALL indicate the decode stage accepts if_id_* this cycle.
REQ-010 if_id_valid  output  1  SHALL indicate if_id_instruction and if_id_pc hold a valid fetched word.
REQ-011 if_id_instruction  output  32  SHALL be the registered fetched instruction.
REQ-012 if_id_pc  output  64  SHALL be the registered address of if_id_instruction.
REQ-013 fetch_fault  output  1  SHALL indicate the FAULT state.
REQ-014 fault_pc  output  64  SHALL be the registered PC that caused the fault.

Function
REQ-015 The block SHALL be a two-state FSM: FETCH and FAULT.
REQ-016 read_address SHALL equal the PC register combinationally, with no additional latency.
REQ-017 The output slot SHALL be free when if_id_valid=0 or id_ready=1.
REQ-018 PC is illegal when PC[1:0]!=0 or PC > MEM_BYTES-4, using an unsigned 64-bit compare.
REQ-019 Priority in both states: branch_taken, then fault detection, then capture, then hold.
REQ-020 On branch_taken=1, the block SHALL set PC<=branch_target and if_id_valid<=0 (flush), and SHALL enter FETCH.
  - The flush applies even when id_ready=0.
  - If the FSM was in FAULT, fetch_fault<=0.
REQ-021 In FETCH with no branch and an illegal PC, the block SHALL enter FAULT with fetch_fault<=1 and fault_pc<=PC.
  - There is no capture and PC holds.
  - if_id_valid<=0 if id_ready=1, otherwise it holds.
REQ-022 In FETCH with no branch, a legal PC and a free slot, the block SHALL capture in one cycle:
  - if_id_instruction<=instruction, if_id_pc<=PC, if_id_valid<=1.
  - PC<=PC+4, modulo 2^64.
REQ-023 In FETCH with the slot not free, PC and all if_id_* SHALL hold (stall).
REQ-024 Fetch-to-decode latency SHALL be one cycle; sustained throughput SHALL be one instruction per cycle while id_ready=1.
REQ-025 In FAULT with no branch, PC, fault_pc and fetch_fault SHALL hold.
  - if_id_valid<=0 when id_ready=1 (drain).
  - There are no new captures.
REQ-026 A branch_target that is illegal SHALL be accepted and then fault on the following cycle per REQ-021.
REQ-027 if_id_instruction and if_id_pc SHALL be don't-care while if_id_valid=0, but SHALL NOT change while if_id_valid=1 and id_ready=0.

Reset
REQ-028 With reset=1 at a clock edge, the block SHALL set:
  - PC<=RESET_PC and state<=FETCH.
  - if_id_valid<=0, if_id_instruction<=0, if_id_pc<=0.
  - fetch_fault<=0, fault_pc<=0.
REQ-029 Reset SHALL override branch_taken and all other inputs, including mid-stall and in FAULT.
REQ-030 The first capture SHALL occur on the first edge after reset deasserts.

Verification
REQ-031 Straight-line fetch: memory words 0x00000013, 0x00100093, 0x00200113 at 0/4/8, id_ready=1 -> if_id_pc 0,4,8 on consecutive cycles with matching instructions and if_id_valid=1.
REQ-032 Stall: id_ready=0 for 3 cycles after the word at 4 is captured -> if_id_pc stays 4, read_address stays 8; one cycle after id_ready=1, if_id_pc=8.
REQ-033 Branch with stall: id_ready=0, branch_taken=1, branch_target=0x40 -> next cycle if_id_valid=0 and read_address=0x40; the next capture has if_id_pc=0x40.
REQ-034 Range fault: sequential fetch reaches PC=128 (MEM_BYTES=128) -> fetch_fault=1, fault_pc=128, no further captures.
  - A subsequent branch_target=0x10 clears fetch_fault and resumes fetch at 0x10.
REQ-035 Misaligned branch and reset recovery:
  - branch_target=0x22 -> FAULT next cycle with fault_pc=0x22.
  - reset=1 for one cycle -> PC=0, all outputs 0, fetch resumes at 0.
